// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss/refill controller: stalls fetch on a miss, streams one block in, commits it.
// Optional ICACHE_CRITICAL_WORD_FIRST_EN: request the missed word first and wrap the fill index.
module icache_fill_ctrl #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned BLOCK_WORDS = 4,
   localparam int unsigned WIDX       = $clog2(BLOCK_WORDS)
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  lookup_valid_i,
   input  logic                  lookup_hit_i,
   input  logic [ADDR_WIDTH-1:0] pc_f_i,
   input  logic                  ic_repl_permit_i,
   output logic                  instr_hit_f_o,
   output logic                  miss_busy_o,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  fill_we_o,
   output logic [WIDX-1:0]       fill_word_o,
   output logic [DATA_WIDTH-1:0] fill_data_o,
   output logic [ADDR_WIDTH-1:0] fill_addr_o,
   output logic                  fill_commit_o
);

   localparam int unsigned BOFF = $clog2(BLOCK_WORDS * DATA_WIDTH / 8);
   localparam int unsigned WOFF = $clog2(DATA_WIDTH / 8);
   localparam logic [WIDX-1:0] LastBeat = WIDX'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {StIdle, StReq, StFill, StCommit} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
   logic [WIDX-1:0]       word_q, word_d;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   // Beat count runs separately from the wrapping word index.
   logic [WIDX-1:0] beat_q, beat_d;
   logic            last_beat;

   assign last_beat  = (beat_q == LastBeat);
   assign mem_addr_o = {miss_addr_q[ADDR_WIDTH-1:WOFF], {WOFF{1'b0}}};

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) beat_q <= '0;
      else            beat_q <= beat_d;
   end
`else
   logic last_beat;

   assign last_beat  = (word_q == LastBeat);
   assign mem_addr_o = {miss_addr_q[ADDR_WIDTH-1:BOFF], {BOFF{1'b0}}};
`endif

   assign fill_word_o = word_q;
   assign fill_data_o = mem_rdata_i;
   assign fill_addr_o = miss_addr_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= StIdle;
         miss_addr_q <= '0;
         word_q      <= '0;
      end else begin
         state_q     <= state_d;
         miss_addr_q <= miss_addr_d;
         word_q      <= word_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      miss_addr_d   = miss_addr_q;
      word_d        = word_q;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      beat_d        = beat_q;
`endif
      instr_hit_f_o = 1'b0;
      miss_busy_o   = 1'b1;
      mem_req_o     = 1'b0;
      fill_we_o     = 1'b0;
      fill_commit_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            miss_busy_o   = 1'b0;
            instr_hit_f_o = ~lookup_valid_i | lookup_hit_i;
            if (lookup_valid_i && !lookup_hit_i) begin
               miss_addr_d = pc_f_i;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
               word_d      = pc_f_i[WOFF +: WIDX];
               beat_d      = '0;
`else
               word_d      = '0;
`endif
               state_d     = StReq;
            end
         end
         StReq: begin
            mem_req_o = 1'b1;
            if (mem_gnt_i) state_d = StFill;
         end
         StFill: begin
            if (mem_rvalid_i) begin
               fill_we_o = 1'b1;
               word_d    = word_q + 1'b1;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
               beat_d    = beat_q + 1'b1;
`endif
               if (last_beat) state_d = StCommit;
            end
         end
         StCommit: begin
            // Wrong-path misses drop the block: data words land but valid/tag never get set.
            fill_commit_o = ic_repl_permit_i;
            state_d       = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl; expectations follow ICACHE_CRITICAL_WORD_FIRST_EN when defined.
module tb_icache_fill_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        lookup_valid, lookup_hit, ic_repl_permit;
   logic [31:0] pc_f;
   logic        instr_hit_f, miss_busy, mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        fill_we;
   logic [1:0]  fill_word;
   logic [31:0] fill_data, fill_addr;
   logic        fill_commit;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   icache_fill_ctrl #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .BLOCK_WORDS(4)
   ) dut (
      .clk_i           (clk),
      .reset_n_i       (reset_n),
      .lookup_valid_i  (lookup_valid),
      .lookup_hit_i    (lookup_hit),
      .pc_f_i          (pc_f),
      .ic_repl_permit_i(ic_repl_permit),
      .instr_hit_f_o   (instr_hit_f),
      .miss_busy_o     (miss_busy),
      .mem_req_o       (mem_req),
      .mem_addr_o      (mem_addr),
      .mem_gnt_i       (mem_gnt),
      .mem_rvalid_i    (mem_rvalid),
      .mem_rdata_i     (mem_rdata),
      .fill_we_o       (fill_we),
      .fill_word_o     (fill_word),
      .fill_data_o     (fill_data),
      .fill_addr_o     (fill_addr),
      .fill_commit_o   (fill_commit)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_maddr(input logic [31:0] pc);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      return pc & 32'hFFFF_FFFC;
`else
      return pc & 32'hFFFF_FFF0;
`endif
   endfunction

   function automatic int exp_w0(input logic [31:0] pc);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      return int'((pc >> 2) & 32'h3);
`else
      return 0;
`endif
   endfunction

   // Starts in IDLE at posedge+1, ends at the COMMIT-cycle sample point.
   task automatic miss_fill(input logic [31:0] pc, input int gdly, input logic permit);
      logic [31:0] ea;
      int          w0;
      ea = exp_maddr(pc);
      w0 = exp_w0(pc);
      lookup_valid = 1'b1; lookup_hit = 1'b0; pc_f = pc;
      #4;
      chk("miss_hit_low", instr_hit_f, 0);
      chk("miss_idle_busy", miss_busy, 0);
      tick;
      for (int d = 0; d < gdly; d++) begin
         mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
         #4;
         chk("req_wait", mem_req, 1);
         chk("req_addr_hold", mem_addr, ea);
         chk("req_busy", miss_busy, 1);
         chk("req_stall", instr_hit_f, 0);
         chk("rvalid_ignored_req", fill_we, 0);
         tick;
      end
      mem_rvalid = 1'b0; mem_gnt = 1'b1;
      #4;
      chk("req_gnt", mem_req, 1);
      chk("req_gnt_addr", mem_addr, ea);
      tick;
      for (int b = 0; b < 4; b++) begin
         mem_rvalid = 1'b0; mem_gnt = 1'b1;
         #4;
         chk("fill_gap_we", fill_we, 0);
         chk("fill_no_req", mem_req, 0);
         tick;
         mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hC0DE_0000 | b;
         #4;
         chk("fill_we", fill_we, 1);
         chk("fill_word", {30'b0, fill_word}, (w0 + b) % 4);
         chk("fill_data", fill_data, 32'hC0DE_0000 | b);
         chk("fill_addr", fill_addr, pc);
         chk("fill_commit_early", fill_commit, 0);
         tick;
      end
      mem_rvalid = 1'b0; ic_repl_permit = permit;
      #4;
      chk("commit", fill_commit, permit);
      chk("commit_busy", miss_busy, 1);
      chk("commit_stall", instr_hit_f, 0);
      chk("commit_we", fill_we, 0);
   endtask

   task automatic resume_hit;
      tick;
      ic_repl_permit = 1'b0; lookup_valid = 1'b1; lookup_hit = 1'b1;
      #4;
      chk("resume_hit", instr_hit_f, 1);
      chk("resume_idle", miss_busy, 0);
      chk("resume_no_commit", fill_commit, 0);
      chk("resume_no_req", mem_req, 0);
   endtask

   initial begin
      reset_n = 1'b0; lookup_valid = 1'b0; lookup_hit = 1'b0; pc_f = '0;
      ic_repl_permit = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      #2;
      chk("rst_busy", miss_busy, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_we", fill_we, 0);
      chk("rst_commit", fill_commit, 0);
      chk("rst_fill_addr", fill_addr, 0);
      tick;
      reset_n = 1'b1;

      // Hits never stall or request.
      lookup_valid = 1'b1; lookup_hit = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #4;
         chk("hit_instr", instr_hit_f, 1);
         chk("hit_req", mem_req, 0);
         chk("hit_busy", miss_busy, 0);
         tick;
      end
      lookup_valid = 1'b0; lookup_hit = 1'b0;
      #4;
      chk("no_lookup_hit", instr_hit_f, 1);
      tick;

      // Committed miss with delayed grant and gapped beats.
      miss_fill(32'h0000_1008, 3, 1'b1);
      resume_hit;
      tick;

      // Wrong-path miss: block streamed in but never committed.
      miss_fill(32'h0000_1008, 3, 1'b0);
      resume_hit;
      tick;

      // Miss on last word of a block.
      miss_fill(32'h0000_100C, 1, 1'b1);
      resume_hit;
      tick;

      // Reset in the middle of a fill.
      lookup_valid = 1'b1; lookup_hit = 1'b0; pc_f = 32'h0000_3004;
      tick;
      mem_gnt = 1'b1;
      tick;
      mem_gnt = 1'b0;
      for (int b = 0; b < 2; b++) begin
         mem_rvalid = 1'b1; mem_rdata = 32'h5555_0000 | b;
         #4;
         chk("pre_rst_word", {30'b0, fill_word}, (exp_w0(32'h0000_3004) + b) % 4);
         tick;
      end
      mem_rvalid = 1'b1; mem_rdata = '0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_hit", instr_hit_f, 0);
      chk("mid_rst_busy", miss_busy, 0);
      chk("mid_rst_req", mem_req, 0);
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_we", fill_we, 0);
      chk("mid_rst_word", {30'b0, fill_word}, 0);
      chk("mid_rst_data", fill_data, 0);
      chk("mid_rst_fill_addr", fill_addr, 0);
      chk("mid_rst_commit", fill_commit, 0);
      mem_rvalid = 1'b0;
      tick;
      reset_n = 1'b1; lookup_hit = 1'b1;
      #4;
      chk("post_rst_hit", instr_hit_f, 1);
      chk("post_rst_busy", miss_busy, 0);
      tick;

      // Back-to-back misses: the second arrives in the first IDLE cycle after COMMIT.
      miss_fill(32'h0000_1008, 0, 1'b1);
      tick;
      ic_repl_permit = 1'b0;
      miss_fill(32'h0000_2000, 0, 1'b1);
      resume_hit;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
